quiz_buzz_ctrl: RTL and testbench

- Controller for a 4-player quiz buzzer.
- Arbitrates the first player key press after the host starts a round.
- Runs a BCD seconds countdown, detects early (foul) presses, and drives a beep pulse.
- Feeds the downstream 3-digit seven-segment display stage via Player_Number, TimerH and TimerL. Code 4'd10 means a blank digit.

---
 rtl/quiz_buzz_ctrl.sv | 169 ++++++++++++++++
 tb/tb_quiz_buzz_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_buzz_ctrl.sv
// Four-player quiz buzzer controller: key conditioning, first-press arbitration,
// BCD seconds countdown, foul detection and a fixed-length beep pulse.
module quiz_buzz_ctrl #(
   parameter int T1S         = 50000000,
   parameter int COUNT_SECS  = 30,
   parameter int BEEP_CYCLES = 25000000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Key_Start,
   input  logic       Key_Clear,
   input  logic [3:0] Key_Player,
   output logic [3:0] Player_Number,
   output logic [3:0] TimerH,
   output logic [3:0] TimerL,
   output logic       Foul_Out,
   output logic       Buzzer_Out
);

   localparam int PRE_W  = (T1S > 1) ? $clog2(T1S) : 1;
   localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

   localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(T1S - 1);
   localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES);
   localparam logic [3:0]        INIT_H    = 4'(COUNT_SECS / 10);
   localparam logic [3:0]        INIT_L    = 4'(COUNT_SECS % 10);
   localparam logic [3:0]        BLANK     = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      LOCKED,
      TIMEOUT,
      FOUL
   } state_t;

   // Key conditioning: {clear, start, player[3:0]}, all active-low at the pins.
   logic [5:0] key_meta_q, key_sync_q, key_prev_q;
   logic [5:0] press_q;

   // NOTE: asynchronous active-low reset; every sequential assignment is
   // non-blocking so all flops sample the same pre-edge values.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         key_meta_q <= '1;
         key_sync_q <= '1;
         key_prev_q <= '1;
         press_q    <= '0;
      end else begin
         key_meta_q <= {Key_Clear, Key_Start, Key_Player};
         key_sync_q <= key_meta_q;
         key_prev_q <= key_sync_q;
         press_q    <= key_prev_q & ~key_sync_q;
      end
   end

   logic       clr_ev, start_ev;
   logic [3:0] ply_ev;

   assign clr_ev   = press_q[5];
   assign start_ev = press_q[4];
   assign ply_ev   = press_q[3:0];

   // Lowest index wins when several players press in the same cycle.
   function automatic logic [3:0] first_player(input logic [3:0] ev);
      if (ev[0])      return 4'd1;
      else if (ev[1]) return 4'd2;
      else if (ev[2]) return 4'd3;
      else if (ev[3]) return 4'd4;
      else            return BLANK;
   endfunction

   state_t              state_q;
   logic [PRE_W-1:0]    pre_q;
   logic [BEEP_W-1:0]   beep_cnt_q;
   logic [3:0]          tmr_h_q, tmr_l_q, player_q;
   logic                foul_q, buzzer_q;

   logic       tick, last_sec, enter_beep;
   logic [3:0] tmr_h_d, tmr_l_d;

   // NOTE: every combinational output gets a default first, so no latch is inferred.
   always_comb begin
      tmr_h_d    = tmr_h_q;
      tmr_l_d    = tmr_l_q - 4'd1;
      if (tmr_l_q == 4'd0) begin
         tmr_h_d = tmr_h_q - 4'd1;
         tmr_l_d = 4'd9;
      end
      tick       = (state_q == ARMED) && (pre_q == PRE_MAX);
      last_sec   = ({tmr_h_q, tmr_l_q} == 8'h01);
      enter_beep = !clr_ev &&
                   (((state_q == IDLE) && |ply_ev) ||
                    ((state_q == ARMED) && (|ply_ev || (tick && last_sec))));
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         beep_cnt_q <= '0;
         tmr_h_q    <= INIT_H;
         tmr_l_q    <= INIT_L;
         player_q   <= BLANK;
         foul_q     <= 1'b0;
         buzzer_q   <= 1'b0;
      end else if (clr_ev) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         beep_cnt_q <= '0;
         tmr_h_q    <= INIT_H;
         tmr_l_q    <= INIT_L;
         player_q   <= BLANK;
         foul_q     <= 1'b0;
         buzzer_q   <= 1'b0;
      end else begin
         if (beep_cnt_q != '0) begin
            beep_cnt_q <= beep_cnt_q - BEEP_W'(1);
            buzzer_q   <= (beep_cnt_q > BEEP_W'(1));
         end
         // A running beep is never restarted by a later entry.
         if (enter_beep && (beep_cnt_q == '0)) begin
            beep_cnt_q <= BEEP_LOAD;
            buzzer_q   <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (|ply_ev) begin
                  state_q  <= FOUL;
                  player_q <= first_player(ply_ev);
                  foul_q   <= 1'b1;
               end else if (start_ev) begin
                  state_q <= ARMED;
                  pre_q   <= '0;
                  tmr_h_q <= INIT_H;
                  tmr_l_q <= INIT_L;
               end
            end
            ARMED: begin
               if (|ply_ev) begin
                  state_q  <= LOCKED;
                  player_q <= first_player(ply_ev);
               end else if (tick) begin
                  pre_q <= '0;
                  if (last_sec) begin
                     state_q <= TIMEOUT;
                     tmr_h_q <= 4'd0;
                     tmr_l_q <= 4'd0;
                  end else begin
                     tmr_h_q <= tmr_h_d;
                     tmr_l_q <= tmr_l_d;
                  end
               end else begin
                  pre_q <= pre_q + PRE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign Player_Number = player_q;
   assign TimerH        = tmr_h_q;
   assign TimerL        = tmr_l_q;
   assign Foul_Out      = foul_q;
   assign Buzzer_Out    = buzzer_q;

endmodule

// File: tb/tb_quiz_buzz_ctrl.sv
// Scoreboard bench for quiz_buzz_ctrl: stimulus queues the expected output
// snapshot and cycle of every change; a negedge monitor pops and compares.
module tb_quiz_buzz_ctrl;

   localparam int T1S  = 10;
   localparam int CS   = 12;
   localparam int BEEP = 5;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic       Key_Start = 1'b1;
   logic       Key_Clear = 1'b1;
   logic [3:0] Key_Player = 4'hF;
   logic [3:0] Player_Number, TimerH, TimerL;
   logic       Foul_Out, Buzzer_Out;

   quiz_buzz_ctrl #(
      .T1S(T1S),
      .COUNT_SECS(CS),
      .BEEP_CYCLES(BEEP)
   ) dut (
      .CLK(CLK),
      .RSTn(RSTn),
      .Key_Start(Key_Start),
      .Key_Clear(Key_Clear),
      .Key_Player(Key_Player),
      .Player_Number(Player_Number),
      .TimerH(TimerH),
      .TimerL(TimerL),
      .Foul_Out(Foul_Out),
      .Buzzer_Out(Buzzer_Out)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int         cyc;
      logic [3:0] pn;
      logic [3:0] th;
      logic [3:0] tl;
      logic       foul;
      logic       buz;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_en = 1'b0;

   logic [13:0] cur_out, prev_out;
   assign cur_out = {Player_Number, TimerH, TimerL, Foul_Out, Buzzer_Out};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: every visible output change must match the next queued expectation.
   always @(negedge CLK) begin
      exp_t e;
      if (mon_en && (cur_out !== prev_out)) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_change: got 0x%0h, expected no change from 0x%0h (cycle %0d)",
                     cur_out, prev_out, cyc);
         end else begin
            e = exp_q.pop_front();
            check("outputs {pn,th,tl,foul,buz}", 32'(cur_out),
                  32'({e.pn, e.th, e.tl, e.foul, e.buz}));
            check("change_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      prev_out = cur_out;
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic expect_out(input int c, input int pn, input int th, input int tl,
                             input logic foul, input logic buz);
      exp_t e;
      e.cyc  = c;
      e.pn   = 4'(pn);
      e.th   = 4'(th);
      e.tl   = 4'(tl);
      e.foul = foul;
      e.buz  = buz;
      exp_q.push_back(e);
   endtask

   // Drive active-low key levels for 'hold' cycles, then release; k = press cycle.
   task automatic keys(input logic s, input logic c, input logic [3:0] p,
                       input int hold, output int k);
      Key_Start  = s;
      Key_Clear  = c;
      Key_Player = p;
      k = cyc;
      step(hold);
      Key_Start  = 1'b1;
      Key_Clear  = 1'b1;
      Key_Player = 4'hF;
   endtask

   // Countdown values seen every T1S cycles after ARMED entry at cycle a.
   task automatic expect_countdown(input int a, input int last_j);
      for (int j = 1; j <= last_j; j++) begin
         expect_out(a + T1S * j, 10, (CS - j) / 10, (CS - j) % 10, 1'b0, 1'b0);
      end
   endtask

   task automatic clear_to_idle();
      int k;
      expect_out(cyc + 4, 10, 1, 2, 1'b0, 1'b0);
      keys(1'b1, 1'b0, 4'hF, 2, k);
      step(8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, a;

      // Reset values
      step(3);
      check("rst_player", 32'(Player_Number), 32'd10);
      check("rst_timer_h", 32'(TimerH), 32'd1);
      check("rst_timer_l", 32'(TimerL), 32'd2);
      check("rst_foul", 32'(Foul_Out), 32'd0);
      check("rst_buzzer", 32'(Buzzer_Out), 32'd0);
      RSTn = 1'b1;
      step(2);
      mon_en = 1'b1;

      // 1: full countdown to TIMEOUT, then a 5-cycle beep; Start ignored afterwards
      keys(1'b0, 1'b1, 4'hF, 3, k);
      a = k + 4;
      expect_countdown(a, 11);
      expect_out(a + 120, 10, 0, 0, 1'b0, 1'b1);
      expect_out(a + 125, 10, 0, 0, 1'b0, 1'b0);
      wait_until(a + 130);
      keys(1'b0, 1'b1, 4'hF, 2, k);
      step(15);
      clear_to_idle();

      // 2: player 3 presses 25 cycles into the round; later player 1 ignored
      keys(1'b0, 1'b1, 4'hF, 3, k);
      a = k + 4;
      expect_out(a + 10, 10, 1, 1, 1'b0, 1'b0);
      expect_out(a + 20, 10, 1, 0, 1'b0, 1'b0);
      wait_until(a + 25);
      expect_out(a + 29, 3, 1, 0, 1'b0, 1'b1);
      expect_out(a + 34, 3, 1, 0, 1'b0, 1'b0);
      keys(1'b1, 1'b1, 4'b1011, 5, k);
      step(5);
      keys(1'b1, 1'b1, 4'b1110, 3, k);
      step(12);
      clear_to_idle();

      // 3: players 2 and 4 in the same cycle -> player 2
      keys(1'b0, 1'b1, 4'hF, 3, k);
      a = k + 4;
      wait_until(a + 2);
      expect_out(a + 6, 2, 1, 2, 1'b0, 1'b1);
      expect_out(a + 11, 2, 1, 2, 1'b0, 1'b0);
      keys(1'b1, 1'b1, 4'b0101, 3, k);
      step(12);
      clear_to_idle();

      // 4: foul by player 4 in IDLE; Start then ignored; Clear restores
      expect_out(cyc + 4, 4, 1, 2, 1'b1, 1'b1);
      expect_out(cyc + 9, 4, 1, 2, 1'b1, 1'b0);
      keys(1'b1, 1'b1, 4'b0111, 3, k);
      step(8);
      keys(1'b0, 1'b1, 4'hF, 3, k);
      step(18);
      expect_out(cyc + 4, 10, 1, 2, 1'b0, 1'b0);
      keys(1'b1, 1'b0, 4'hF, 2, k);
      step(8);

      // 4b: Start and player 1 in the same IDLE cycle -> foul wins
      expect_out(cyc + 4, 1, 1, 2, 1'b1, 1'b1);
      expect_out(cyc + 9, 1, 1, 2, 1'b1, 1'b0);
      keys(1'b0, 1'b1, 4'b1110, 3, k);
      step(20);
      expect_out(cyc + 4, 10, 1, 2, 1'b0, 1'b0);
      keys(1'b1, 1'b0, 4'hF, 2, k);
      step(8);

      // 5: press lands on the final tick -> LOCKED at 01, single beep
      keys(1'b0, 1'b1, 4'hF, 3, k);
      a = k + 4;
      expect_countdown(a, 11);
      wait_until(a + 116);
      expect_out(a + 120, 1, 0, 1, 1'b0, 1'b1);
      expect_out(a + 125, 1, 0, 1, 1'b0, 1'b0);
      keys(1'b1, 1'b1, 4'b1110, 3, k);
      step(25);
      expect_out(cyc + 4, 10, 1, 2, 1'b0, 1'b0);
      keys(1'b1, 1'b0, 4'hF, 2, k);
      step(8);

      // 6a: asynchronous reset while the beep is running
      keys(1'b0, 1'b1, 4'hF, 3, k);
      a = k + 4;
      expect_out(a + 10, 10, 1, 1, 1'b0, 1'b0);
      wait_until(a + 15);
      expect_out(a + 19, 2, 1, 1, 1'b0, 1'b1);
      keys(1'b1, 1'b1, 4'b1101, 3, k);
      wait_until(a + 21);
      expect_out(a + 21, 10, 1, 2, 1'b0, 1'b0);
      RSTn = 1'b0;
      #1;
      check("async_rst_buzzer", 32'(Buzzer_Out), 32'd0);
      check("async_rst_player", 32'(Player_Number), 32'd10);
      check("async_rst_timer", 32'({TimerH, TimerL}), 32'h12);
      step(2);
      RSTn = 1'b1;
      step(12);

      // 6b: Clear while a foul beep is running
      expect_out(cyc + 4, 4, 1, 2, 1'b1, 1'b1);
      keys(1'b1, 1'b1, 4'b0111, 1, k);
      step(1);
      expect_out(k + 6, 10, 1, 2, 1'b0, 1'b0);
      keys(1'b1, 1'b0, 4'hF, 2, k);
      step(12);

      mon_en = 1'b0;
      check("pending_expectations", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
